// File: rtl/tone_sequencer_if.sv
// Bundles the jingle trigger inputs and the amplifier-facing outputs.
// The master side drives the trigger levels and the slave (the
// sequencer) drives the audio and status outputs.
interface tone_sequencer_if;
  logic winrnd;
  logic right;
  logic tie;
  logic speaker;
  logic en;
  logic gain;
  logic busy;

  modport master (
    output winrnd, right, tie,
    input  speaker, en, gain, busy
  );

  modport slave (
    input  winrnd, right, tie,
    output speaker, en, gain, busy
  );
endinterface

// File: rtl/tone_sequencer.sv
// Two-note jingle player. A rising edge on (winrnd | tie) starts a
// note / gap / note sequence whose pitches depend on who won the round.
// The speaker is a square wave built from a half-period counter, and
// every note starts from a low speaker level.
module tone_sequencer #(
  parameter int HALF_HI  = 25,
  parameter int HALF_LO  = 50,
  parameter int HALF_TIE = 38,
  parameter int NOTE_LEN = 1000,
  parameter int GAP_LEN  = 200
) (
  input  logic            clk,
  input  logic            rst,
  tone_sequencer_if.slave bus
);

  localparam int DUR_MAX   = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int HALF_MAX0 = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;
  localparam int HALF_MAX  = (HALF_MAX0 > HALF_TIE) ? HALF_MAX0 : HALF_TIE;
  localparam int DUR_W     = $clog2(DUR_MAX + 1);
  localparam int HALF_W    = $clog2(HALF_MAX + 1);

  localparam logic [DUR_W-1:0]  NOTE_LAST = DUR_W'(NOTE_LEN - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_LEN - 1);
  localparam logic [HALF_W-1:0] HI_LAST   = HALF_W'(HALF_HI - 1);
  localparam logic [HALF_W-1:0] LO_LAST   = HALF_W'(HALF_LO - 1);
  localparam logic [HALF_W-1:0] TIE_LAST  = HALF_W'(HALF_TIE - 1);

  typedef enum logic [1:0] {IDLE, NOTE1, GAP, NOTE2} state_t;
  typedef enum logic [1:0] {KIND_TIE, KIND_LEFT, KIND_RIGHT} kind_t;

  state_t            state_reg;
  kind_t             kind_reg;
  logic [DUR_W-1:0]  dur_cnt_reg;
  logic [HALF_W-1:0] half_cnt_reg;
  logic              prev_trig_reg;
  logic              speaker_reg;
  logic              en_reg;
  logic              busy_reg;
  logic              gain_reg;

  logic              trig_level;
  logic              trig;
  logic [HALF_W-1:0] half_last;

  assign trig_level = bus.winrnd | bus.tie;
  assign trig       = trig_level & ~prev_trig_reg;

  // Pick the half-period of the note now sounding: the winner's pair is
  // played in opposite order for left and right, a tie repeats one pitch.
  always_comb begin
    half_last = TIE_LAST;
    if (kind_reg == KIND_RIGHT) begin
      half_last = (state_reg == NOTE1) ? LO_LAST : HI_LAST;
    end else if (kind_reg == KIND_LEFT) begin
      half_last = (state_reg == NOTE1) ? HI_LAST : LO_LAST;
    end
  end

  // Sequencer FSM with edge detector, duration and tone counters; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      kind_reg      <= KIND_TIE;
      dur_cnt_reg   <= '0;
      half_cnt_reg  <= '0;
      prev_trig_reg <= 1'b0;
      speaker_reg   <= 1'b0;
      en_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      gain_reg      <= 1'b1;
    end else begin
      // The previous value tracks the input in every state, so triggers
      // during a jingle are consumed rather than queued.
      prev_trig_reg <= trig_level;
      gain_reg      <= 1'b1;
      case (state_reg)
        IDLE: begin
          speaker_reg <= 1'b0;
          en_reg      <= 1'b0;
          busy_reg    <= 1'b0;
          if (trig) begin
            state_reg    <= NOTE1;
            dur_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            en_reg       <= 1'b1;
            busy_reg     <= 1'b1;
            if (bus.tie) begin
              kind_reg <= KIND_TIE;
            end else if (bus.right) begin
              kind_reg <= KIND_RIGHT;
            end else begin
              kind_reg <= KIND_LEFT;
            end
          end
        end
        NOTE1, NOTE2: begin
          if (dur_cnt_reg == NOTE_LAST) begin
            dur_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            speaker_reg  <= 1'b0;
            en_reg       <= 1'b0;
            if (state_reg == NOTE1) begin
              state_reg <= GAP;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            dur_cnt_reg <= dur_cnt_reg + DUR_W'(1);
            if (half_cnt_reg == half_last) begin
              half_cnt_reg <= '0;
              speaker_reg  <= ~speaker_reg;
            end else begin
              half_cnt_reg <= half_cnt_reg + HALF_W'(1);
            end
          end
        end
        GAP: begin
          speaker_reg <= 1'b0;
          if (dur_cnt_reg == GAP_LAST) begin
            state_reg    <= NOTE2;
            dur_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            en_reg       <= 1'b1;
          end else begin
            dur_cnt_reg <= dur_cnt_reg + DUR_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.speaker = speaker_reg;
  assign bus.en      = en_reg;
  assign bus.busy    = busy_reg;
  assign bus.gain    = gain_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at default parameters: each jingle is
// sampled every cycle on the falling edge and compared with hand-derived
// note timing (note 1 in samples 1..1000, gap 1001..1200, note 2 1201..2200).
module tb_tone_sequencer;

  localparam int NOTE_END  = 1000;
  localparam int NOTE2_BEG = 1201;
  localparam int BUSY_LEN  = 2200;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tone_sequencer_if bus ();

  tone_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Observe one jingle whose trigger level was driven at the preceding
  // falling edge. Sample c corresponds to the c-th rising edge counting the
  // trigger edge as 1.
  task automatic run_jingle(input string tag, input int h1, input int h2,
                            input int len, input bit hold, input int pulse_at);
    int busy_cnt  = 0;
    int en_cnt    = 0;
    int busy_rise = 0;
    int spk_bad   = 0;
    int gain_low  = 0;
    int first1    = 0;
    int first2    = 0;
    int exp_spk;
    logic busy_prev  = 1'b0;
    logic busy_first = 1'b0;
    logic en_first   = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busy_first = bus.busy;
        en_first   = bus.en;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.en === 1'b1) en_cnt++;
      if (bus.busy === 1'b1 && busy_prev !== 1'b1) busy_rise++;
      busy_prev = bus.busy;
      if (bus.gain !== 1'b1) gain_low++;
      if (c <= NOTE_END) exp_spk = ((c - 1) / h1) % 2;
      else if (c >= NOTE2_BEG && c <= BUSY_LEN) exp_spk = ((c - NOTE2_BEG) / h2) % 2;
      else exp_spk = 0;
      if (bus.speaker !== exp_spk[0]) spk_bad++;
      if (first1 == 0 && c <= NOTE_END && bus.speaker === 1'b1) first1 = c;
      if (first2 == 0 && c >= NOTE2_BEG && c <= BUSY_LEN && bus.speaker === 1'b1) first2 = c;
      if (!hold && c == 3) begin
        bus.winrnd = 1'b0;
        bus.tie    = 1'b0;
      end
      if (c == pulse_at) bus.winrnd = 1'b1;
      if (c == pulse_at + 1) bus.winrnd = 1'b0;
    end
    bus.winrnd = 1'b0;
    bus.tie    = 1'b0;
    check({tag, "_busy_at_1"}, 32'(busy_first), 32'd1);
    check({tag, "_en_at_1"}, 32'(en_first), 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, BUSY_LEN);
    check({tag, "_busy_rises"}, busy_rise, 1);
    check({tag, "_en_cycles"}, en_cnt, 2 * NOTE_END);
    check({tag, "_note1_first_high"}, first1, h1 + 1);
    check({tag, "_note2_first_high"}, first2, NOTE2_BEG + h2);
    check({tag, "_speaker_bad_cycles"}, spk_bad, 0);
    check({tag, "_gain_low_cycles"}, gain_low, 0);
    $display("jingle %s: busy=%0d en=%0d first1=%0d first2=%0d spk_bad=%0d",
             tag, busy_cnt, en_cnt, first1, first2, spk_bad);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.winrnd = 1'b0;
    bus.right  = 1'b0;
    bus.tie    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_speaker", 32'(bus.speaker), 32'd0);
    check("rst_en", 32'(bus.en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gain", 32'(bus.gain), 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_gain", 32'(bus.gain), 32'd1);

    // Right winner: LO then HI
    bus.winrnd = 1'b1; bus.right = 1'b1;
    run_jingle("right", 50, 25, 2400, 1'b0, -1);

    // Left winner: HI then LO
    bus.winrnd = 1'b1; bus.right = 1'b0;
    run_jingle("left", 25, 50, 2400, 1'b0, -1);

    // Tie and winrnd together: tie wins, two TIE notes
    bus.winrnd = 1'b1; bus.tie = 1'b1; bus.right = 1'b1;
    run_jingle("tie", 38, 38, 2400, 1'b0, -1);

    // Second pulse 500 cycles in is discarded
    bus.winrnd = 1'b1; bus.right = 1'b1;
    run_jingle("retrig", 50, 25, 2400, 1'b0, 500);

    // Level held for 5000 cycles gives one jingle
    bus.winrnd = 1'b1; bus.right = 1'b0;
    run_jingle("hold", 25, 50, 5000, 1'b1, -1);

    // Reset 300 cycles into NOTE1 aborts at once
    bus.winrnd = 1'b1; bus.right = 1'b1;
    repeat (300) @(negedge clk);
    check("pre_rst_speaker", 32'(bus.speaker), 32'd1);
    check("pre_rst_en", 32'(bus.en), 32'd1);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_speaker", 32'(bus.speaker), 32'd0);
    check("async_rst_en", 32'(bus.en), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_gain", 32'(bus.gain), 32'd1);
    $display("reset mid-note: speaker=%0d en=%0d busy=%0d", bus.speaker, bus.en, bus.busy);
    bus.right = 1'b0;
    @(negedge clk);
    // winrnd still high through release: exactly one LEFT jingle follows
    rst = 1'b0;
    run_jingle("after_rst", 25, 50, 2400, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter HALF_HI, default 25: half-period in clk cycles of the high tone.
REQ-002 Parameter HALF_LO, default 50: half-period in clk cycles of the low tone.
REQ-003 Parameter HALF_TIE, default 38: half-period in clk cycles of the tie tone.
REQ-004 Parameter NOTE_LEN, default 1000: duration of each note in clk cycles.
REQ-005 Parameter GAP_LEN, default 200: silent gap between the two notes, in clk cycles.
REQ-006 clk  in  1  the single clock of the block, the divided game clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 winrnd  in  1  round-won level from the push-button stage.
REQ-009 right  in  1  winner side, 1 = right player; valid while winrnd=1.
REQ-010 tie  in  1  tie-round level from the push-button stage.
REQ-011 speaker  out  1  square-wave audio to the amplifier.
REQ-012 en  out  1  amplifier enable; 1 only while a note is sounding.
REQ-013 gain  out  1  amplifier gain select; constant 1 out of reset.
REQ-014 busy  out  1  high while a jingle is in progress (any state except IDLE).

Function
REQ-015 Trigger = rising edge of (winrnd | tie), detected against a registered previous value; a level held high produces exactly one trigger.
REQ-016 On the trigger edge, latch the kind: TIE if tie=1 (tie wins over a simultaneous winrnd); otherwise RIGHT if right=1, else LEFT.
REQ-017 Sequences: RIGHT = LO note then HI note; LEFT = HI note then LO note; TIE = TIE note twice.
REQ-018 FSM states IDLE, NOTE1, GAP, NOTE2; IDLE->NOTE1 on trigger; NOTE1->GAP after NOTE_LEN cycles; GAP->NOTE2 after GAP_LEN cycles; NOTE2->IDLE after NOTE_LEN cycles.
REQ-019 Latency: trigger seen at rising edge k; state=NOTE1, en=1, busy=1 from edge k+1.
REQ-020 Total busy time is exactly 2*NOTE_LEN+GAP_LEN cycles; busy falls and en falls on the same edge.
REQ-021 A trigger arriving while busy=1 is discarded, never queued; the previous-value register still updates, so a level that is still high after IDLE is reached does not retrigger.
REQ-022 Tone generator: a half-period counter reloads to 0 at every note start; speaker toggles when the counter reaches HALF-1, then the counter returns to 0; first toggle is HALF cycles after note start.
REQ-023 speaker is forced 0 in IDLE and GAP, and at every note start, so each note begins from 0.
REQ-024 The duration counter is wide enough for max(NOTE_LEN, GAP_LEN) with no wrap; the half-period counter is wide enough for max(HALF_HI, HALF_LO, HALF_TIE).
REQ-025 en = 1 in NOTE1 and NOTE2 only; gain is never driven 0 after reset.

Reset
REQ-026 While rst=1 (asynchronously): state=IDLE, speaker=0, en=0, busy=0, gain=1, all counters 0, kind=TIE, previous-trigger register=0.
REQ-027 Reset mid-jingle aborts immediately with no residual tone; a trigger input held high through reset release produces one trigger on the first edge after release.

Verification
REQ-028 Reset, then winrnd=1 with right=1 held -> busy and en rise 1 cycle later; NOTE1 speaker period 100 cycles (LO), then 200 silent cycles, then NOTE2 period 50 cycles (HI); busy=0 after 2200 cycles.
REQ-029 winrnd=1 with right=0 -> HI note (period 50) then LO note (period 100).
REQ-030 tie=1 and winrnd=1 on the same edge -> two TIE notes, period 76 each.
REQ-031 Second winrnd pulse 500 cycles into a jingle -> ignored; busy still falls at cycle 2200 with no further jingle.
REQ-032 rst asserted 300 cycles into NOTE1 -> speaker=0, en=0, busy=0 at once, with no clock edge required.
REQ-033 winrnd held high for 5000 cycles -> exactly one jingle; gain=1 throughout.
